tlk2711_rx_deframer: RTL and testbench

Receive-side deframer sitting directly downstream of the TLK2711 receive pins (rxd/rkmsb/rklsb), already brought into the `clk` domain. It finds SOF/EOF K-code delimiters and strips the length header and checksum. Payload words are forwarded cut-through to the RX DMA writer. Per-frame good/error status and a loss-of-sync level feed the `tlk2711_rx_irq` / `tlk2711_los` interrupt paths.

---
 rtl/tlk2711_pkg.sv | 52 +++++
 rtl/tlk2711_los_det.sv | 38 +++
 rtl/tlk2711_rx_deframer.sv | 206 ++++++++++++++++++++
 tb/tb_tlk2711_rx_deframer.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlk2711_pkg.sv
// Shared constants and types for the TLK2711 receive deframer.
// Holds the K-code values, FSM states, error codes and word classification.
package tlk2711_pkg;

    localparam logic [15:0] K_SOF  = 16'hFBFB;
    localparam logic [15:0] K_EOF  = 16'hFDFD;
    localparam logic [15:0] K_DERR = 16'hFEFE;
    localparam logic [15:0] K_IDLE = 16'hC5BC;

    localparam logic [2:0] ERR_NONE  = 3'd0;
    localparam logic [2:0] ERR_LEN   = 3'd1;
    localparam logic [2:0] ERR_KCHAR = 3'd2;
    localparam logic [2:0] ERR_SUM   = 3'd3;
    localparam logic [2:0] ERR_EOF   = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CHK,
        ST_EOFW
    } state_t;

    typedef enum logic [2:0] {
        WC_DATA,
        WC_SOF,
        WC_EOF,
        WC_DERR,
        WC_IDLE,
        WC_OTHERK
    } word_class_t;

    // IDLE is the only delimiter carried with a single K flag (lsb only).
    function automatic word_class_t classify(input logic [15:0] rxd,
                                             input logic        kmsb,
                                             input logic        klsb);
        word_class_t c;
        c = WC_OTHERK;
        if (!kmsb && !klsb)
            c = WC_DATA;
        else if (kmsb && klsb && rxd == K_SOF)
            c = WC_SOF;
        else if (kmsb && klsb && rxd == K_EOF)
            c = WC_EOF;
        else if (kmsb && klsb && rxd == K_DERR)
            c = WC_DERR;
        else if (!kmsb && klsb && rxd == K_IDLE)
            c = WC_IDLE;
        return c;
    endfunction

endpackage

// File: rtl/tlk2711_los_det.sv
// Loss-of-sync detector: counts consecutive decode-error words and holds
// o_loss from the threshold-reaching DERR until the next IDLE word.
module tlk2711_los_det #(
    parameter int LOSS_THRESH = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_derr,
    input  logic i_idle,
    output logic o_loss
);

    localparam int              CW        = $clog2(LOSS_THRESH + 1);
    localparam logic [CW-1:0]   LP_THRESH = CW'(LOSS_THRESH);

    logic [CW-1:0] r_cnt;
    logic          r_loss;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_cnt  <= '0;
            r_loss <= 1'b0;
        end else if (i_idle) begin
            r_cnt  <= '0;
            r_loss <= 1'b0;
        end else if (i_derr) begin
            if (r_cnt != LP_THRESH)
                r_cnt <= r_cnt + CW'(1);
            if (r_cnt >= LP_THRESH - CW'(1))
                r_loss <= 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    assign o_loss = r_loss;

endmodule

// File: rtl/tlk2711_rx_deframer.sv
// TLK2711 receive deframer: delimits SOF/LEN/payload/SUM/EOF frames, forwards
// payload cut-through and reports per-frame status, counters and loss-of-sync.
module tlk2711_rx_deframer
    import tlk2711_pkg::*;
#(
    parameter int MAX_LEN     = 4096,
    parameter int LOSS_THRESH = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [15:0] i_rxd,
    input  logic        i_rkmsb,
    input  logic        i_rklsb,
    output logic [15:0] o_data,
    output logic        o_valid,
    output logic        o_sof,
    output logic        o_eof,
    output logic        o_frame_done,
    output logic        o_frame_err,
    output logic [2:0]  o_err_code,
    output logic [31:0] o_frame_cnt,
    output logic [15:0] o_err_cnt,
    output logic        o_loss
);

    logic [15:0] r_rxd;
    logic        r_rkmsb;
    logic        r_rklsb;

    state_t      r_state;
    state_t      w_next_state;
    word_class_t w_cls;

    logic [12:0] r_len;
    logic [12:0] r_cnt;
    logic [12:0] w_cnt_inc;
    logic [15:0] r_sum;

    logic        w_len_ok;
    logic        w_last;
    logic        w_load;
    logic        w_emit;
    logic        w_done;
    logic        w_err;
    logic [2:0]  w_err_code;

    logic [15:0] r_data;
    logic        r_valid;
    logic        r_sof;
    logic        r_eof;
    logic        r_frame_done;
    logic        r_frame_err;
    logic [2:0]  r_err_code;
    logic [31:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rxd   <= '0;
            r_rkmsb <= 1'b0;
            r_rklsb <= 1'b0;
        end else begin
            r_rxd   <= i_rxd;
            r_rkmsb <= i_rkmsb;
            r_rklsb <= i_rklsb;
        end
    end

    assign w_cls     = classify(r_rxd, r_rkmsb, r_rklsb);
    assign w_len_ok  = (r_rxd != 16'd0) && ({16'd0, r_rxd} <= 32'(MAX_LEN));
    assign w_cnt_inc = r_cnt + 13'd1;
    assign w_last    = (w_cnt_inc == r_len);

    always_ff @(posedge clk) begin
        if (!rstn)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    // A SOF restarts header parsing from any state so the new frame survives.
    always_comb begin
        w_next_state = r_state;
        if (w_cls == WC_SOF) begin
            w_next_state = ST_HDR;
        end else begin
            case (r_state)
                ST_IDLE:    w_next_state = ST_IDLE;
                ST_HDR:     w_next_state = (w_cls == WC_DATA && w_len_ok) ? ST_PAYLOAD : ST_IDLE;
                ST_PAYLOAD: w_next_state = (w_cls != WC_DATA) ? ST_IDLE :
                                           (w_last ? ST_CHK : ST_PAYLOAD);
                ST_CHK:     w_next_state = (w_cls == WC_DATA && r_rxd == r_sum) ? ST_EOFW : ST_IDLE;
                ST_EOFW:    w_next_state = ST_IDLE;
                default:    w_next_state = ST_IDLE;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no latches are inferred.
    always_comb begin
        w_load     = 1'b0;
        w_emit     = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        case (r_state)
            ST_HDR: begin
                if (w_cls != WC_DATA) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_KCHAR;
                end else if (!w_len_ok) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_LEN;
                end else begin
                    w_load     = 1'b1;
                end
            end
            ST_PAYLOAD: begin
                if (w_cls == WC_DATA) begin
                    w_emit     = 1'b1;
                end else begin
                    w_err      = 1'b1;
                    w_err_code = ERR_KCHAR;
                end
            end
            ST_CHK: begin
                if (w_cls != WC_DATA) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_KCHAR;
                end else if (r_rxd != r_sum) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_SUM;
                end
            end
            ST_EOFW: begin
                if (w_cls == WC_EOF) begin
                    w_done     = 1'b1;
                end else begin
                    w_err      = 1'b1;
                    w_err_code = ERR_EOF;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_len        <= '0;
            r_cnt        <= '0;
            r_sum        <= '0;
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_sof        <= 1'b0;
            r_eof        <= 1'b0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_frame_cnt  <= '0;
            r_err_cnt    <= '0;
        end else begin
            r_valid      <= w_emit;
            r_sof        <= w_emit && (r_cnt == 13'd0);
            r_eof        <= w_emit && w_last;
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
            r_err_code   <= w_err_code;
            if (w_emit)
                r_data <= r_rxd;
            if (w_load) begin
                r_len <= r_rxd[12:0];
                r_sum <= r_rxd;
                r_cnt <= '0;
            end else if (w_emit) begin
                r_sum <= r_sum + r_rxd;
                r_cnt <= w_cnt_inc;
            end
            if (r_frame_done)
                r_frame_cnt <= r_frame_cnt + 32'd1;
            if (r_frame_err && r_err_cnt != 16'hFFFF)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    tlk2711_los_det #(
        .LOSS_THRESH (LOSS_THRESH)
    ) u_los_det (
        .clk    (clk),
        .rstn   (rstn),
        .i_derr (w_cls == WC_DERR),
        .i_idle (w_cls == WC_IDLE),
        .o_loss (o_loss)
    );

    assign o_data       = r_data;
    assign o_valid      = r_valid;
    assign o_sof        = r_sof;
    assign o_eof        = r_eof;
    assign o_frame_done = r_frame_done;
    assign o_frame_err  = r_frame_err;
    assign o_err_code   = r_err_code;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_tlk2711_rx_deframer.sv
// Self-checking bench for tlk2711_rx_deframer: frames are built at frame level
// and each driven word carries the output event it must produce 2 cycles later.
module tb_tlk2711_rx_deframer;

    localparam logic [15:0] LP_SOF  = 16'hFBFB;
    localparam logic [15:0] LP_EOF  = 16'hFDFD;
    localparam logic [15:0] LP_DERR = 16'hFEFE;
    localparam logic [15:0] LP_IDLE = 16'hC5BC;

    localparam int KD_GOOD   = 0;
    localparam int KD_BADSUM = 1;
    localparam int KD_SOFCUT = 2;
    localparam int KD_KCUT   = 3;
    localparam int KD_BADEOF = 4;
    localparam int KD_SOFEOF = 5;
    localparam int KD_BADLEN = 6;

    typedef struct packed {
        logic        valid;
        logic        sof;
        logic        eof;
        logic [15:0] data;
        logic        done;
        logic        err;
        logic [2:0]  code;
        logic        loss;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic [15:0] i_rxd;
    logic        i_rkmsb;
    logic        i_rklsb;
    logic [15:0] o_data;
    logic        o_valid;
    logic        o_sof;
    logic        o_eof;
    logic        o_frame_done;
    logic        o_frame_err;
    logic [2:0]  o_err_code;
    logic [31:0] o_frame_cnt;
    logic [15:0] o_err_cnt;
    logic        o_loss;

    int          total;
    int          bad;
    exp_t        pend[$];
    logic [31:0] m_fcnt;
    logic [15:0] m_ecnt;
    int          m_run;
    logic        m_loss;
    logic [15:0] pl[$];

    tlk2711_rx_deframer #(
        .MAX_LEN     (4096),
        .LOSS_THRESH (16)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_rxd        (i_rxd),
        .i_rkmsb      (i_rkmsb),
        .i_rklsb      (i_rklsb),
        .o_data       (o_data),
        .o_valid      (o_valid),
        .o_sof        (o_sof),
        .o_eof        (o_eof),
        .o_frame_done (o_frame_done),
        .o_frame_err  (o_frame_err),
        .o_err_code   (o_err_code),
        .o_frame_cnt  (o_frame_cnt),
        .o_err_cnt    (o_err_cnt),
        .o_loss       (o_loss)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_cycle(input exp_t x);
        check("frame_cnt", o_frame_cnt, m_fcnt);
        check("err_cnt", 32'(o_err_cnt), 32'(m_ecnt));
        check("valid", 32'(o_valid), 32'(x.valid));
        check("sof", 32'(o_sof), 32'(x.sof));
        check("eof", 32'(o_eof), 32'(x.eof));
        check("frame_done", 32'(o_frame_done), 32'(x.done));
        check("frame_err", 32'(o_frame_err), 32'(x.err));
        check("loss", 32'(o_loss), 32'(x.loss));
        if (x.valid)
            check("data", 32'(o_data), 32'(x.data));
        if (x.err)
            check("err_code", 32'(o_err_code), 32'(x.code));
        if (x.done)
            m_fcnt = m_fcnt + 32'd1;
        if (x.err && m_ecnt != 16'hFFFF)
            m_ecnt = m_ecnt + 16'd1;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_sof"}, 32'(o_sof), 32'd0);
        check({tag, "_eof"}, 32'(o_eof), 32'd0);
        check({tag, "_data"}, 32'(o_data), 32'd0);
        check({tag, "_done"}, 32'(o_frame_done), 32'd0);
        check({tag, "_err"}, 32'(o_frame_err), 32'd0);
        check({tag, "_code"}, 32'(o_err_code), 32'd0);
        check({tag, "_fcnt"}, o_frame_cnt, 32'd0);
        check({tag, "_ecnt"}, 32'(o_err_cnt), 32'd0);
        check({tag, "_loss"}, 32'(o_loss), 32'd0);
    endtask

    // Drive one word; the expectation for the word driven two steps earlier is due now.
    task automatic step(input logic [15:0] d, input logic km, input logic kl, input exp_t e);
        exp_t x;
        exp_t ee;
        @(posedge clk);
        #1;
        if (pend.size() == 2) begin
            x = pend.pop_front();
            check_cycle(x);
        end
        i_rxd   = d;
        i_rkmsb = km;
        i_rklsb = kl;
        if (!km && kl && d == LP_IDLE) begin
            m_run  = 0;
            m_loss = 1'b0;
        end else if (km && kl && d == LP_DERR) begin
            m_run++;
            if (m_run >= 16)
                m_loss = 1'b1;
        end else begin
            m_run = 0;
        end
        ee      = e;
        ee.loss = m_loss;
        pend.push_back(ee);
    endtask

    task automatic idle(input int n);
        repeat (n) step(LP_IDLE, 1'b0, 1'b1, '0);
    endtask

    function automatic exp_t err_exp(input logic [2:0] code);
        exp_t e;
        e      = '0;
        e.err  = 1'b1;
        e.code = code;
        return e;
    endfunction

    task automatic send_badlen(input logic [15:0] len, input bit skip_sof);
        if (!skip_sof)
            step(LP_SOF, 1'b1, 1'b1, '0);
        step(len, 1'b0, 1'b0, err_exp(3'd1));
    endtask

    task automatic send_frame(input logic [15:0] p[$], input int kind, input int pos, input bit skip_sof);
        exp_t        e;
        logic [15:0] sum;
        int          n;
        n   = p.size();
        sum = 16'(n);
        if (!skip_sof)
            step(LP_SOF, 1'b1, 1'b1, '0);
        step(16'(n), 1'b0, 1'b0, '0);
        for (int i = 0; i < n; i++) begin
            if (kind == KD_SOFCUT && i == pos) begin
                step(LP_SOF, 1'b1, 1'b1, err_exp(3'd2));
                return;
            end
            if (kind == KD_KCUT && i == pos) begin
                step(LP_EOF, 1'b1, 1'b1, err_exp(3'd2));
                return;
            end
            e       = '0;
            e.valid = 1'b1;
            e.sof   = (i == 0);
            e.eof   = (i == n - 1);
            e.data  = p[i];
            step(p[i], 1'b0, 1'b0, e);
            sum = sum + p[i];
        end
        if (kind == KD_BADSUM) begin
            step(sum - 16'd1, 1'b0, 1'b0, err_exp(3'd3));
            return;
        end
        step(sum, 1'b0, 1'b0, '0);
        if (kind == KD_BADEOF) begin
            step(16'($urandom), 1'b0, 1'b0, err_exp(3'd4));
        end else if (kind == KD_SOFEOF) begin
            step(LP_SOF, 1'b1, 1'b1, err_exp(3'd4));
        end else begin
            e      = '0;
            e.done = 1'b1;
            step(LP_EOF, 1'b1, 1'b1, e);
        end
    endtask

    task automatic rand_payload(input int n);
        pl.delete();
        for (int i = 0; i < n; i++)
            pl.push_back(16'($urandom));
    endtask

    initial begin
        bit skip;
        int kind;
        int len;
        int pos;
        int g;

        total   = 0;
        bad     = 0;
        m_fcnt  = '0;
        m_ecnt  = '0;
        m_run   = 0;
        m_loss  = 1'b0;
        rstn    = 1'b0;
        i_rxd   = LP_IDLE;
        i_rkmsb = 1'b0;
        i_rklsb = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check_zero("reset");
        rstn = 1'b1;

        // Clean LEN=3 frame, then the same frame with SUM one short.
        pl = '{16'h0001, 16'h0002, 16'h0003};
        send_frame(pl, KD_GOOD, 0, 1'b0);
        idle(3);
        send_frame(pl, KD_BADSUM, 0, 1'b0);
        idle(3);

        // Length limits.
        send_badlen(16'd0, 1'b0);
        idle(2);
        send_badlen(16'd4097, 1'b0);
        idle(2);
        send_badlen(16'hFFFF, 1'b0);
        idle(2);

        // SOF after 2 of 5 payload words, new frame is a single word.
        rand_payload(5);
        send_frame(pl, KD_SOFCUT, 2, 1'b0);
        rand_payload(1);
        send_frame(pl, KD_GOOD, 0, 1'b1);
        idle(3);

        // Loss of sync: threshold, hold across data, clear on IDLE.
        repeat (15) step(LP_DERR, 1'b1, 1'b1, '0);
        step(LP_DERR, 1'b1, 1'b1, '0);
        repeat (3) step(16'($urandom), 1'b0, 1'b0, '0);
        step(LP_IDLE, 1'b0, 1'b1, '0);
        idle(3);

        // Largest legal frame.
        rand_payload(4096);
        send_frame(pl, KD_GOOD, 0, 1'b0);
        idle(2);

        // Random mix of good and damaged frames with assorted gap words.
        skip = 1'b0;
        for (int f = 0; f < 60; f++) begin
            kind = $urandom_range(0, 6);
            len  = ($urandom_range(0, 3) == 0) ? $urandom_range(9, 40) : $urandom_range(1, 8);
            rand_payload(len);
            pos  = $urandom_range(0, len - 1);
            if (kind == KD_BADLEN)
                send_badlen(($urandom_range(0, 1) == 0) ? 16'd0 : 16'($urandom_range(4097, 65535)), skip);
            else
                send_frame(pl, kind, pos, skip);
            skip = (kind == KD_SOFCUT || kind == KD_SOFEOF);
            if (!skip) begin
                repeat ($urandom_range(0, 3)) begin
                    g = $urandom_range(0, 3);
                    case (g)
                        0:       step(LP_IDLE, 1'b0, 1'b1, '0);
                        1:       step(LP_DERR, 1'b1, 1'b1, '0);
                        2:       step(16'($urandom), 1'b0, 1'b0, '0);
                        default: step(LP_EOF, 1'b1, 1'b1, '0);
                    endcase
                end
            end
        end
        if (skip) begin
            rand_payload(2);
            send_frame(pl, KD_GOOD, 0, 1'b1);
        end
        idle(3);

        // Reset in the middle of a payload abandons the frame silently.
        rand_payload(5);
        step(LP_SOF, 1'b1, 1'b1, '0);
        step(16'd5, 1'b0, 1'b0, '0);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e       = '0;
            e.valid = 1'b1;
            e.sof   = (i == 0);
            e.data  = pl[i];
            step(pl[i], 1'b0, 1'b0, e);
        end
        rstn    = 1'b0;
        i_rxd   = LP_IDLE;
        i_rkmsb = 1'b0;
        i_rklsb = 1'b1;
        pend.delete();
        m_fcnt  = '0;
        m_ecnt  = '0;
        m_run   = 0;
        m_loss  = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_zero("midreset");
        end
        rstn = 1'b1;
        rand_payload(4);
        send_frame(pl, KD_GOOD, 0, 1'b0);
        idle(4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
